// File: rtl/motor_pkg.sv
// Shared types and widths for the STEP/DIR decoder slice.
// Holds the decoder FSM state enum and the counter/position widths.
package motor_pkg;

   localparam int CNT_W = 16;
   localparam int POS_W = 32;

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      RISE = 2'd1,
      HIGH = 2'd2,
      FALL = 2'd3
   } state_t;

   // A programmed length of zero behaves as a length of one.
   function automatic logic [CNT_W-1:0] qual_len(input logic [CNT_W-1:0] n);
      return (n == 16'd0) ? 16'd1 : n;
   endfunction

endpackage

// File: rtl/step_dir_decoder_if.sv
// Bundle of STEP/DIR lines, configuration, position commands and decoder results.
interface step_dir_decoder_if;
   import motor_pkg::*;

   logic                    step_in;
   logic                    dir_in;
   logic [CNT_W-1:0]        min_high_n;
   logic [CNT_W-1:0]        min_low_n;
   logic [CNT_W-1:0]        setup_n;
   logic                    set_x;
   logic signed [POS_W-1:0] x_val;
   logic                    hold;
   logic                    clr_err;
   logic                    step_stb;
   logic                    step_dir;
   logic signed [POS_W-1:0] x;
   logic signed [POS_W-1:0] x_hold;
   logic                    glitch;
   logic                    setup_err;

   modport master (
      output step_in, dir_in, min_high_n, min_low_n, setup_n,
             set_x, x_val, hold, clr_err,
      input  step_stb, step_dir, x, x_hold, glitch, setup_err
   );

   modport slave (
      input  step_in, dir_in, min_high_n, min_low_n, setup_n,
             set_x, x_val, hold, clr_err,
      output step_stb, step_dir, x, x_hold, glitch, setup_err
   );

endinterface

// File: rtl/step_dir_decoder_sync2.sv
// Two-flop synchronizer for one asynchronous line; both flops clear on reset.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // Synchronizer chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/step_dir_decoder.sv
// Qualifies STEP pulses against programmable high/low lengths, checks DIR setup,
// and accumulates a signed position with load and snapshot controls.
module step_dir_decoder
   import motor_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   step_dir_decoder_if.slave bus
);

   logic                    step_s;
   logic                    dir_s;
   logic                    dir_prev_r;
   logic                    dir_chg_s;
   state_t                  state_r;
   state_t                  state_nx_s;
   logic [CNT_W-1:0]        qcnt_r;
   logic [CNT_W-1:0]        qcnt_nx_s;
   logic [CNT_W-1:0]        dstab_r;
   logic                    step_stb_r;
   logic                    stb_nx_s;
   logic                    step_dir_r;
   logic                    step_dir_nx_s;
   logic                    glitch_set_s;
   logic                    setup_qual_s;
   logic                    setup_set_s;
   logic                    in_window_s;
   logic signed [POS_W-1:0] x_r;
   logic signed [POS_W-1:0] x_hold_r;
   logic                    glitch_r;
   logic                    setup_err_r;

   sync2 u_sync_step (.clk(clk), .reset(reset), .d(bus.step_in), .q(step_s));
   sync2 u_sync_dir  (.clk(clk), .reset(reset), .d(bus.dir_in),  .q(dir_s));

   // DIR must stay put from the start of a rising qualification until STEP falls.
   assign dir_chg_s   = dir_s ^ dir_prev_r;
   assign in_window_s = (state_r == RISE) || (state_r == HIGH);
   assign setup_set_s = setup_qual_s | (in_window_s & dir_chg_s);

   // Next-state, qualification counter and step strobe decode.
   always_comb begin
      state_nx_s    = state_r;
      qcnt_nx_s     = qcnt_r;
      stb_nx_s      = 1'b0;
      step_dir_nx_s = step_dir_r;
      glitch_set_s  = 1'b0;
      setup_qual_s  = 1'b0;
      case (state_r)
         LOW: begin
            if (step_s) begin
               state_nx_s    = RISE;
               qcnt_nx_s     = 16'd1;
               step_dir_nx_s = dir_s;
            end else begin
               state_nx_s    = LOW;
            end
         end
         RISE: begin
            if (!step_s) begin
               state_nx_s   = LOW;
               glitch_set_s = 1'b1;
            end else if (qcnt_r >= qual_len(bus.min_high_n)) begin
               state_nx_s   = HIGH;
               stb_nx_s     = 1'b1;
               setup_qual_s = (dstab_r < bus.setup_n);
            end else begin
               qcnt_nx_s    = qcnt_r + 16'd1;
            end
         end
         HIGH: begin
            if (!step_s) begin
               state_nx_s = FALL;
               qcnt_nx_s  = 16'd1;
            end else begin
               state_nx_s = HIGH;
            end
         end
         FALL: begin
            if (step_s) begin
               state_nx_s   = HIGH;
               glitch_set_s = 1'b1;
            end else if (qcnt_r >= qual_len(bus.min_low_n)) begin
               state_nx_s   = LOW;
            end else begin
               qcnt_nx_s    = qcnt_r + 16'd1;
            end
         end
         default: begin
            state_nx_s = LOW;
            qcnt_nx_s  = 16'd0;
         end
      endcase
   end

   // FSM state, strobe and DIR-stability tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= LOW;
         qcnt_r     <= 16'd0;
         step_stb_r <= 1'b0;
         step_dir_r <= 1'b0;
         dir_prev_r <= 1'b0;
         dstab_r    <= 16'd0;
      end else begin
         state_r    <= state_nx_s;
         qcnt_r     <= qcnt_nx_s;
         step_stb_r <= stb_nx_s;
         step_dir_r <= step_dir_nx_s;
         dir_prev_r <= dir_s;
         if (dir_chg_s) begin
            dstab_r <= 16'd0;
         end else if (dstab_r != 16'hFFFF) begin
            dstab_r <= dstab_r + 16'd1;
         end else begin
            dstab_r <= dstab_r;
         end
      end
   end

   // Position accumulator and snapshot; a load discards a coincident step.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_r      <= 32'sd0;
         x_hold_r <= 32'sd0;
      end else begin
         if (bus.set_x) begin
            x_r <= bus.x_val;
         end else if (step_stb_r) begin
            x_r <= step_dir_r ? (x_r - 32'sd1) : (x_r + 32'sd1);
         end else begin
            x_r <= x_r;
         end
         if (bus.hold) begin
            x_hold_r <= x_r;
         end else begin
            x_hold_r <= x_hold_r;
         end
      end
   end

   // Sticky error flags; a new error outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_r    <= 1'b0;
         setup_err_r <= 1'b0;
      end else begin
         if (glitch_set_s) begin
            glitch_r <= 1'b1;
         end else if (bus.clr_err) begin
            glitch_r <= 1'b0;
         end else begin
            glitch_r <= glitch_r;
         end
         if (setup_set_s) begin
            setup_err_r <= 1'b1;
         end else if (bus.clr_err) begin
            setup_err_r <= 1'b0;
         end else begin
            setup_err_r <= setup_err_r;
         end
      end
   end

   assign bus.step_stb  = step_stb_r;
   assign bus.step_dir  = step_dir_r;
   assign bus.x         = x_r;
   assign bus.x_hold    = x_hold_r;
   assign bus.glitch    = glitch_r;
   assign bus.setup_err = setup_err_r;

endmodule
